// File: rtl/fraction_accumulator.sv
// Accumulates signed Q1.6 multiplier products into a wide sum of LEN terms and hands it off over valid/ready.
// Define FRACTION_ACC_SAT_EN to saturate on overflow instead of wrapping.
module fraction_accumulator #(
   parameter int ACC_W = 12,
   parameter int LEN   = 4
) (
   input  logic             CLK,
   input  logic             Rst_n,
   input  logic             Clr,
   input  logic [6:0]       Product,
   input  logic             Done,
   output logic [ACC_W-1:0] Sum,
   output logic             SumValid,
   input  logic             SumReady,
   output logic [7:0]       TermCnt,
   output logic             Overflow,
   output logic             Dropped
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [7:0] LEN_C = 8'(LEN);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       term_cnt_q, term_cnt_d;
   logic             overflow_q, overflow_d;
   logic             dropped_q, dropped_d;

   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] raw_sum;
   logic [ACC_W-1:0] add_result;
   logic             add_ovf;
   logic             start_sum;

   assign addend  = {{(ACC_W-7){Product[6]}}, Product};
   assign raw_sum = acc_q + addend;
   assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                    (raw_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef FRACTION_ACC_SAT_EN
   // Clamp towards the sign both addends share.
   always_comb begin
      add_result = raw_sum;
      if (add_ovf) begin
         add_result = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign add_result = raw_sum;
`endif

   // A completed transfer with a simultaneous product starts the next sum directly.
   assign start_sum = Done && ((state_q == IDLE) || ((state_q == HOLD) && SumReady));

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      term_cnt_d = term_cnt_q;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      if (Clr) begin
         state_d    = IDLE;
         acc_d      = '0;
         term_cnt_d = '0;
         overflow_d = 1'b0;
         dropped_d  = 1'b0;
      end else if (start_sum) begin
         state_d    = (LEN_C == 8'd1) ? HOLD : ACCUM;
         acc_d      = addend;
         term_cnt_d = 8'd1;
         overflow_d = 1'b0;
         dropped_d  = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (Done) begin
                  acc_d      = add_result;
                  term_cnt_d = term_cnt_q + 8'd1;
                  if (add_ovf) overflow_d = 1'b1;
                  if ((term_cnt_q + 8'd1) == LEN_C) state_d = HOLD;
               end
            end
            HOLD: begin
               if (SumReady) state_d = IDLE;
               else if (Done) dropped_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         term_cnt_q <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         term_cnt_q <= term_cnt_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   assign Sum      = acc_q;
   assign SumValid = (state_q == HOLD);
   assign TermCnt  = term_cnt_q;
   assign Overflow = overflow_q;
   assign Dropped  = dropped_q;

endmodule

// File: tb/tb_fraction_accumulator.sv
// Directed bench for fraction_accumulator: a 12-bit and an 8-bit instance share all inputs.
module tb_fraction_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic [6:0]  product;
   logic        done;
   logic        sum_ready;

   logic [11:0] sum12;
   logic        sum_valid12;
   logic [7:0]  term_cnt12;
   logic        overflow12;
   logic        dropped12;

   logic [7:0]  sum8;
   logic        sum_valid8;
   logic [7:0]  term_cnt8;
   logic        overflow8;
   logic        dropped8;

   int compare_count  = 0;
   int mismatch_count = 0;

   fraction_accumulator #(.ACC_W(12), .LEN(4)) u_dut12 (
      .CLK(clk), .Rst_n(rst_n), .Clr(clr), .Product(product), .Done(done),
      .Sum(sum12), .SumValid(sum_valid12), .SumReady(sum_ready),
      .TermCnt(term_cnt12), .Overflow(overflow12), .Dropped(dropped12)
   );

   fraction_accumulator #(.ACC_W(8), .LEN(4)) u_dut8 (
      .CLK(clk), .Rst_n(rst_n), .Clr(clr), .Product(product), .Done(done),
      .Sum(sum8), .SumValid(sum_valid8), .SumReady(sum_ready),
      .TermCnt(term_cnt8), .Overflow(overflow8), .Dropped(dropped8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", tag, observed, expected);
      end
   endtask

   // One Done pulse carrying p; returns 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic [6:0] p);
      done    = 1'b1;
      product = p;
      @(posedge clk);
      #1;
      done    = 1'b0;
      product = '0;
   endtask

   initial begin
      logic [7:0] exp_sum8;
`ifdef FRACTION_ACC_SAT_EN
      exp_sum8 = 8'h7F;
`else
      exp_sum8 = 8'hFC;
`endif
      rst_n = 1'b0; clr = 1'b0; product = '0; done = 1'b0; sum_ready = 1'b0;
      #12;
      checkOutput("reset_sum",      32'(sum12),       32'h0);
      checkOutput("reset_valid",    32'(sum_valid12), 32'h0);
      checkOutput("reset_termcnt",  32'(term_cnt12),  32'h0);
      checkOutput("reset_overflow", 32'(overflow12),  32'h0);
      checkOutput("reset_dropped",  32'(dropped12),   32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic sum: 4 x +0.375 = +1.5, consumer always ready
      sum_ready = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(7'h18);
      checkOutput("basic_not_valid_early", 32'(sum_valid12), 32'h0);
      applyStimulus(7'h18);
      checkOutput("basic_valid",    32'(sum_valid12), 32'h1);
      checkOutput("basic_sum",      32'(sum12),       32'h060);
      checkOutput("basic_termcnt",  32'(term_cnt12),  32'h4);
      checkOutput("basic_overflow", 32'(overflow12),  32'h0);
      @(posedge clk); #1;
      checkOutput("basic_released", 32'(sum_valid12), 32'h0);
      sum_ready = 1'b0;

      // Mixed signs: -0.25 + 0.25 - 1.0 + 0.5 = -0.5
      applyStimulus(7'h70);
      applyStimulus(7'h10);
      applyStimulus(7'h40);
      applyStimulus(7'h20);
      checkOutput("mixed_sum",     32'(sum12),       32'hFE0);
      checkOutput("mixed_termcnt", 32'(term_cnt12),  32'h4);
      checkOutput("mixed_valid",   32'(sum_valid12), 32'h1);

      // Stall in HOLD, then a product arrives and is dropped
      repeat (10) @(posedge clk);
      #1;
      checkOutput("hold_stall_valid", 32'(sum_valid12), 32'h1);
      checkOutput("hold_stall_sum",   32'(sum12),       32'hFE0);
      applyStimulus(7'h05);
      checkOutput("drop_flag",  32'(dropped12),   32'h1);
      checkOutput("drop_sum",   32'(sum12),       32'hFE0);
      checkOutput("drop_valid", 32'(sum_valid12), 32'h1);

      // Ready together with Done: transfer completes and the product opens the next sum
      sum_ready = 1'b1;
      applyStimulus(7'h08);
      sum_ready = 1'b0;
      checkOutput("b2b_valid",   32'(sum_valid12), 32'h0);
      checkOutput("b2b_acc",     32'(sum12),       32'h008);
      checkOutput("b2b_termcnt", 32'(term_cnt12),  32'h1);
      checkOutput("b2b_dropped", 32'(dropped12),   32'h0);
      applyStimulus(7'h08);
      checkOutput("b2b_term2", 32'(term_cnt12), 32'h2);

      // Clr in the same cycle as the third product
      clr = 1'b1;
      applyStimulus(7'h08);
      clr = 1'b0;
      checkOutput("clr_acc",     32'(sum12),       32'h0);
      checkOutput("clr_termcnt", 32'(term_cnt12),  32'h0);
      checkOutput("clr_valid",   32'(sum_valid12), 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(7'h18);
      checkOutput("clean_sum",      32'(sum12),       32'h060);
      checkOutput("clean_valid",    32'(sum_valid12), 32'h1);
      checkOutput("clean_overflow", 32'(overflow12),  32'h0);
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;
      checkOutput("clean_released", 32'(sum_valid12), 32'h0);

      // Overflow: 4 x 0x3F into an 8-bit accumulator
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(7'h3F);
      checkOutput("ovf8_sum",        32'(sum8),        32'(exp_sum8));
      checkOutput("ovf8_flag",       32'(overflow8),   32'h1);
      checkOutput("ovf8_valid",      32'(sum_valid8),  32'h1);
      checkOutput("ovf12_sum",       32'(sum12),       32'h0FC);
      checkOutput("ovf12_flag",      32'(overflow12),  32'h0);
      sum_ready = 1'b1;
      @(posedge clk); #1;
      sum_ready = 1'b0;

      // Asynchronous reset between clock edges mid-ACCUM
      for (int i = 0; i < 3; i++) applyStimulus(7'h3F);
      checkOutput("prereset_termcnt",  32'(term_cnt12), 32'h3);
      checkOutput("prereset_overflow", 32'(overflow8),  32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_sum",       32'(sum12),       32'h0);
      checkOutput("async_termcnt",   32'(term_cnt12),  32'h0);
      checkOutput("async_valid",     32'(sum_valid12), 32'h0);
      checkOutput("async_overflow8", 32'(overflow8),   32'h0);
      checkOutput("async_sum8",      32'(sum8),        32'h0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("postreset_sum",   32'(sum12),       32'h0);
      checkOutput("postreset_valid", 32'(sum_valid12), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
